alu_result_queue: RTL and testbench

//  Registered result stage directly downstream of the 32-bit ALU. Captures

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_result_queue_if.sv | 30 +++
 rtl/sync_fifo.sv | 82 ++++++++
 rtl/alu_result_queue.sv | 87 ++++++++
 tb/tb_alu_result_queue.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control encodings, arithmetic-op decode and the
// layout of one buffered result entry.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // add and sub share these low control bits; only they produce cout/overflow
  localparam logic [1:0] OP_ARITH_LSB = 2'b10;

  localparam int RESULT_W = 32;
  localparam int FLAGS_W  = 3;
  localparam int CTRL_W   = 4;
  localparam int ENTRY_W  = RESULT_W + FLAGS_W + CTRL_W;

  // flags are {overflow, cout, zero}
  typedef struct packed {
    logic [RESULT_W-1:0] result;
    logic [FLAGS_W-1:0]  flags;
    logic [CTRL_W-1:0]   ctrl;
  } entry_t;

  function automatic logic is_arith(input logic [CTRL_W-1:0] ctrl);
    return (ctrl[1:0] == OP_ARITH_LSB);
  endfunction

endpackage

// File: rtl/alu_result_queue_if.sv
// Producer/consumer bundle around the ALU result queue. The slave view is
// the queue itself; the master view is whoever drives ALU results in and
// takes them out.
interface alu_result_queue_if;
  import alu_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [RESULT_W-1:0] in_result;
  logic                in_zero;
  logic                in_cout;
  logic                in_overflow;
  logic [CTRL_W-1:0]   in_ctrl;

  logic                out_valid;
  logic                out_ready;
  logic [RESULT_W-1:0] out_result;
  logic [FLAGS_W-1:0]  out_flags;
  logic [CTRL_W-1:0]   out_ctrl;

  modport slave (
    input  in_valid, in_result, in_zero, in_cout, in_overflow, in_ctrl, out_ready,
    output in_ready, out_valid, out_result, out_flags, out_ctrl
  );

  modport master (
    output in_valid, in_result, in_zero, in_cout, in_overflow, in_ctrl, out_ready,
    input  in_ready, out_valid, out_result, out_flags, out_ctrl
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head entry. Pointers carry one extra
// wrap bit so full and empty are distinguished without a separate counter.
// The head register is loaded at the same edge that makes an entry the
// oldest one, so a push into an empty FIFO is visible the next cycle, and
// it reads zero whenever the FIFO is empty.
module sync_fifo #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r, rd_ptr_r;
  logic [AW:0]      wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [WIDTH-1:0] head_r, head_nxt_s;
  logic             push_s, pop_s;

  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty = (wr_ptr_r == rd_ptr_r);
  assign level = wr_ptr_r - rd_ptr_r;

  // a full FIFO refuses writes even when a pop happens in the same cycle
  assign push_s  = wr_en & ~full;
  assign pop_s   = rd_en & ~empty;
  assign rd_data = head_r;

  // next pointers and the entry that will sit at the head after this edge
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    head_nxt_s   = '0;
    if (push_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    if (wr_ptr_nxt_s == rd_ptr_nxt_s) begin
      head_nxt_s = '0;
    end else if (push_s && (wr_ptr_r[AW-1:0] == rd_ptr_nxt_s[AW-1:0])) begin
      // the entry being written becomes the oldest one
      head_nxt_s = wr_data;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s[AW-1:0]];
    end
  end

  // pointer and head registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      head_r   <= '0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      head_r   <= head_nxt_s;
    end
  end

  // storage array; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end
endmodule

// File: rtl/alu_result_queue.sv
// Result stage behind the ALU: buffers {result, flags, ctrl} so a stalled
// consumer never loses a result, masks carry/overflow for non-arithmetic
// ops, and tracks a sticky overflow flag and a saturating add/sub count.
module alu_result_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_result_queue_if.slave      bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   sticky_ovf,
  input  logic                   sticky_clr,
  output logic [CNT_W-1:0]       arith_cnt
);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  entry_t             wr_entry_s;
  entry_t             head_s;
  logic [ENTRY_W-1:0] head_raw_s;
  logic               full_s, empty_s;
  logic               arith_s, push_s;
  logic               sticky_ovf_r;
  logic [CNT_W-1:0]   arith_cnt_r;

  assign arith_s      = is_arith(bus.in_ctrl);
  assign bus.in_ready = ~full_s;
  assign push_s       = bus.in_valid & ~full_s;

  // build the stored entry; logic ops never report carry or overflow
  always_comb begin
    wr_entry_s        = '0;
    wr_entry_s.result = bus.in_result;
    wr_entry_s.flags  = {bus.in_overflow & arith_s, bus.in_cout & arith_s, bus.in_zero};
    wr_entry_s.ctrl   = bus.in_ctrl;
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.in_valid),
    .wr_data (wr_entry_s),
    .rd_en   (bus.out_ready),
    .rd_data (head_raw_s),
    .full    (full_s),
    .empty   (empty_s),
    .level   (level)
  );

  assign head_s         = head_raw_s;
  assign bus.out_valid  = ~empty_s;
  assign bus.out_result = head_s.result;
  assign bus.out_flags  = head_s.flags;
  assign bus.out_ctrl   = head_s.ctrl;

  // sticky overflow: a new overflow takes priority over a clear request
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_ovf_r <= 1'b0;
    end else if (push_s && arith_s && bus.in_overflow) begin
      sticky_ovf_r <= 1'b1;
    end else if (sticky_clr) begin
      sticky_ovf_r <= 1'b0;
    end else begin
      sticky_ovf_r <= sticky_ovf_r;
    end
  end

  // saturating count of accepted add/sub ops
  always_ff @(posedge clk) begin
    if (rst) begin
      arith_cnt_r <= '0;
    end else if (push_s && arith_s && (arith_cnt_r != {CNT_W{1'b1}})) begin
      arith_cnt_r <= arith_cnt_r + CNT_ONE;
    end else begin
      arith_cnt_r <= arith_cnt_r;
    end
  end

  assign sticky_ovf = sticky_ovf_r;
  assign arith_cnt  = arith_cnt_r;
endmodule

// File: tb/tb_alu_result_queue.sv
// Bench for alu_result_queue: directed scenarios followed by random traffic,
// all checked against a queue-based reference model.
module tb_alu_result_queue;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        sticky_clr;
  logic [2:0]  level;
  logic        sticky_ovf;
  logic [15:0] arith_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  // reference model state
  logic [38:0] mq[$];
  bit          m_sticky;
  int          m_cnt;

  always #5 clk = ~clk;

  alu_result_queue_if bus();

  alu_result_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .level      (level),
    .sticky_ovf (sticky_ovf),
    .sticky_clr (sticky_clr),
    .arith_cnt  (arith_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [38:0] head;
    head = (mq.size() > 0) ? mq[0] : 39'd0;
    check_eq({tag, ".level"},     level,          mq.size());
    check_eq({tag, ".out_valid"}, bus.out_valid,  mq.size() > 0);
    check_eq({tag, ".in_ready"},  bus.in_ready,   mq.size() < DEPTH);
    check_eq({tag, ".result"},    bus.out_result, head[38:7]);
    check_eq({tag, ".flags"},     bus.out_flags,  head[6:4]);
    check_eq({tag, ".ctrl"},      bus.out_ctrl,   head[3:0]);
    check_eq({tag, ".sticky"},    sticky_ovf,     m_sticky);
    check_eq({tag, ".cnt"},       arith_cnt,      m_cnt);
  endtask

  // drive one cycle from the negedge, advance the model, check at next negedge
  task automatic step(input bit r, input bit iv, input logic [31:0] res,
                      input bit z, input bit c, input bit o, input logic [3:0] ctl,
                      input bit ordy, input bit sclr, input string tag);
    bit can_push, do_pop, ar;
    rst = r; bus.in_valid = iv; bus.in_result = res; bus.in_zero = z;
    bus.in_cout = c; bus.in_overflow = o; bus.in_ctrl = ctl;
    bus.out_ready = ordy; sticky_clr = sclr;
    if (r) begin
      mq.delete();
      m_sticky = 1'b0;
      m_cnt    = 0;
    end else begin
      can_push = iv && (mq.size() < DEPTH);
      do_pop   = ordy && (mq.size() > 0);
      ar       = (ctl == ALU_ADD) || (ctl == ALU_SUB) || (ctl[1:0] == 2'b10);
      if (do_pop) void'(mq.pop_front());
      if (can_push) mq.push_back({res, o && ar, c && ar, z, ctl});
      if (can_push && ar && o) m_sticky = 1'b1;
      else if (sclr) m_sticky = 1'b0;
      if (can_push && ar && m_cnt < 65535) m_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle(input bit ordy, input string tag);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, ALU_AND, ordy, 1'b0, tag);
  endtask

  logic [3:0] ops [6];
  int         saved_cnt;

  initial begin
    ops[0] = ALU_AND; ops[1] = ALU_OR;  ops[2] = ALU_ADD;
    ops[3] = ALU_SUB; ops[4] = ALU_SLT; ops[5] = ALU_NOR;
    rst = 1'b1; sticky_clr = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_result = 32'd0; bus.in_zero = 1'b0; bus.in_cout = 1'b0;
    bus.in_overflow = 1'b0; bus.in_ctrl = 4'd0;
    m_sticky = 1'b0; m_cnt = 0;
    @(negedge clk);

    // 1: reset then idle
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, ALU_AND, 1'b0, 1'b0, "t1_rst0");
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, ALU_AND, 1'b0, 1'b0, "t1_rst1");
    idle(1'b0, "t1_idle");
    check_eq("t1_level", level, 64'd0);
    check_eq("t1_in_ready", bus.in_ready, 64'd1);
    check_eq("t1_cnt", arith_cnt, 64'd0);

    // 2: overflowing ADD is visible the next cycle
    step(1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, ALU_ADD, 1'b1, 1'b0, "t2_push");
    check_eq("t2_result", bus.out_result, 64'h8000_0000);
    check_eq("t2_flags", bus.out_flags, 64'h4);
    check_eq("t2_sticky", sticky_ovf, 64'd1);
    check_eq("t2_cnt", arith_cnt, 64'd1);
    idle(1'b1, "t2_pop");

    // 3: fill with five AND ops, fifth refused, then drain in order
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b1, 32'(i), 1'b0, 1'b0, 1'b0, ALU_AND, 1'b0, 1'b0, "t3_push");
      if (i == 4) check_eq("t3_full_ready", bus.in_ready, 64'd0);
    end
    check_eq("t3_level_full", level, 64'd4);
    for (int i = 1; i <= 4; i++) begin
      check_eq("t3_order", bus.out_result, 64'(i));
      idle(1'b1, "t3_drain");
    end
    check_eq("t3_level_empty", level, 64'd0);

    // 4: full with push and pop together: pop only, push accepted next cycle
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 32'(10 + i), 1'b0, 1'b0, 1'b0, ALU_NOR, 1'b0, 1'b0, "t4_fill");
    step(1'b0, 1'b1, 32'd20, 1'b1, 1'b0, 1'b0, ALU_SLT, 1'b1, 1'b0, "t4_both");
    check_eq("t4_level3", level, 64'd3);
    step(1'b0, 1'b1, 32'd20, 1'b1, 1'b0, 1'b0, ALU_SLT, 1'b0, 1'b0, "t4_retry");
    check_eq("t4_level4", level, 64'd4);
    for (int i = 0; i < 4; i++) idle(1'b1, "t4_drain");

    // 5: OR op has cout/overflow masked and does not touch sticky or count
    saved_cnt = m_cnt;
    step(1'b0, 1'b1, 32'd7, 1'b0, 1'b1, 1'b1, ALU_OR, 1'b0, 1'b0, "t5_push");
    check_eq("t5_flags_hi", bus.out_flags[2:1], 64'd0);
    check_eq("t5_sticky", sticky_ovf, 64'd1);
    check_eq("t5_cnt", arith_cnt, 64'(saved_cnt));
    idle(1'b1, "t5_pop");

    // 6: clear, then clear racing an overflowing SUB; then reset mid-stream
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, ALU_AND, 1'b0, 1'b1, "t6_clr");
    check_eq("t6_cleared", sticky_ovf, 64'd0);
    step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, ALU_SUB, 1'b0, 1'b1, "t6_race");
    check_eq("t6_set_wins", sticky_ovf, 64'd1);
    step(1'b0, 1'b1, 32'd1, 1'b0, 1'b0, 1'b0, ALU_AND, 1'b0, 1'b0, "t6_q2");
    step(1'b0, 1'b1, 32'd2, 1'b0, 1'b0, 1'b0, ALU_AND, 1'b0, 1'b0, "t6_q3");
    check_eq("t6_level3", level, 64'd3);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, ALU_AND, 1'b0, 1'b0, "t6_rst");
    check_eq("t6_rst_level", level, 64'd0);
    check_eq("t6_rst_valid", bus.out_valid, 64'd0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      step(($urandom % 80) == 0, $urandom_range(0, 1) == 1, $urandom,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, ops[$urandom_range(0, 5)],
           ($urandom % 3) != 0, ($urandom % 8) == 0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
